// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, branch condition codes, {Z,V,N}
// flag bit positions, and the per-opcode flag write mask.
package cpu_pkg;

  // ALU opcodes
  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_XOR    = 3'b010;
  localparam logic [2:0] OP_RED    = 3'b011;
  localparam logic [2:0] OP_SLL    = 3'b100;
  localparam logic [2:0] OP_SRA    = 3'b101;
  localparam logic [2:0] OP_ROR    = 3'b110;
  localparam logic [2:0] OP_PADDSB = 3'b111;

  // Branch condition codes
  localparam logic [2:0] COND_NE  = 3'b000;
  localparam logic [2:0] COND_EQ  = 3'b001;
  localparam logic [2:0] COND_GT  = 3'b010;
  localparam logic [2:0] COND_LT  = 3'b011;
  localparam logic [2:0] COND_GE  = 3'b100;
  localparam logic [2:0] COND_LE  = 3'b101;
  localparam logic [2:0] COND_OV  = 3'b110;
  localparam logic [2:0] COND_ALW = 3'b111;

  // Bit positions within the {Z,V,N} flag vector
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 0;

  // Branch interlock states
  typedef enum logic {
    BR_IDLE = 1'b0,
    BR_WAIT = 1'b1
  } br_state_t;

  // Which {Z,V,N} bits an opcode is allowed to update.
  function automatic logic [2:0] flag_wr_mask(input logic [2:0] op);
    logic [2:0] m;
    m = '0;
    case (op)
      OP_ADD, OP_SUB:                 m = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = 3'b100;
      default:                        m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition resolver: condition code + {Z,V,N} -> taken.
module branch_cond_eval
  import cpu_pkg::*;
#(
  parameter int unsigned FLAG_W = 3,
  parameter int unsigned COND_W = 3
) (
  input  logic [COND_W-1:0] cond,
  input  logic [FLAG_W-1:0] flags,
  output logic              taken
);

  logic w_z;
  logic w_v;
  logic w_n;

  assign w_z = flags[FLAG_Z];
  assign w_v = flags[FLAG_V];
  assign w_n = flags[FLAG_N];

  // Decode the condition code against the current flags
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_NE:  taken = !w_z;
      COND_EQ:  taken = w_z;
      COND_GT:  taken = !w_z && !w_n;
      COND_LT:  taken = w_n;
      COND_GE:  taken = w_z || !w_n;
      COND_LE:  taken = w_z || w_n;
      COND_OV:  taken = w_v;
      default:  taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural {Z,V,N} flag register plus conditional branch resolver.
// A branch in ID that sees a flag writer in EX waits one cycle in BR_WAIT
// so it resolves against the committed flags rather than forwarded ones.
module flag_branch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned FLAG_W = 3,
  parameter int unsigned COND_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_alu_valid,
  input  logic [2:0]        ex_op,
  input  logic [FLAG_W-1:0] ex_flags,
  input  logic              hold,
  input  logic              id_br_valid,
  input  logic [COND_W-1:0] id_br_cond,
  output logic              br_stall,
  output logic              br_done,
  output logic              br_taken,
  output logic [FLAG_W-1:0] flags
);

  br_state_t         r_state;
  logic [FLAG_W-1:0] r_flags;
  logic              r_br_done;
  logic              r_br_taken;

  logic [FLAG_W-1:0] w_mask;
  logic              w_haz;
  logic              w_accept;
  logic              w_taken;

  assign w_mask = flag_wr_mask(ex_op);
  assign w_haz  = ex_alu_valid && (w_mask != '0);

  // In BR_WAIT the older writer has already committed, so any writer now in
  // EX is younger than the branch and must not block it.
  assign w_accept = id_br_valid && !hold && ((r_state == BR_WAIT) || !w_haz);
  assign br_stall = id_br_valid && !w_accept;

  branch_cond_eval #(
    .FLAG_W (FLAG_W),
    .COND_W (COND_W)
  ) u_cond (
    .cond  (id_br_cond),
    .flags (r_flags),
    .taken (w_taken)
  );

  // Masked commit of ALU flags as the instruction leaves EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else if (ex_alu_valid && !hold) begin
      r_flags <= (r_flags & ~w_mask) | (ex_flags & w_mask);
    end
  end

  // Branch interlock FSM with registered resolve outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= BR_IDLE;
      r_br_done  <= 1'b0;
      r_br_taken <= 1'b0;
    end else begin
      r_br_done <= 1'b0;
      if (!hold) begin
        case (r_state)
          BR_IDLE: begin
            if (id_br_valid) begin
              if (w_haz) begin
                r_state <= BR_WAIT;
              end else begin
                r_br_done  <= 1'b1;
                r_br_taken <= w_taken;
              end
            end
          end
          BR_WAIT: begin
            r_state <= BR_IDLE;
            if (id_br_valid) begin
              r_br_done  <= 1'b1;
              r_br_taken <= w_taken;
            end
          end
          default: r_state <= BR_IDLE;
        endcase
      end
    end
  end

  assign flags    = r_flags;
  assign br_done  = r_br_done;
  assign br_taken = r_br_taken;

endmodule

// File: doc/flag_branch_unit.md
# flag_branch_unit

Flag register and branch-condition resolver for the 16-bit pipelined CPU; the consumer end of the ALU's `{Z,V,N}` flag interface. It commits ALU flags per-opcode as instructions leave EX, holds them architecturally, and resolves conditional branches presented from ID. A one-state wait FSM interlocks a branch behind an in-flight flag writer instead of forwarding flags combinationally.

## Interface
Parameters:
- `FLAG_W`, 3: flag width, ordered `{Z,V,N}`; fixed by the ISA.
- `COND_W`, 3: branch condition-code width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ex_alu_valid`  in  1  a flag-eligible ALU instruction is in EX this cycle; bubbles and LW/SW address adds drive 0.
- `ex_op`  in  3  ALU opcode: 000 ADD, 001 SUB, 010 XOR, 011 RED, 100 SLL, 101 SRA, 110 ROR, 111 PADDSB.
- `ex_flags`  in  3  ALU `{Z,V,N}` for the EX instruction.
- `hold`  in  1  pipeline freeze: no flag commit, no branch acceptance, FSM holds state.
- `id_br_valid`  in  1  conditional branch in ID; held until accepted.
- `id_br_cond`  in  3  condition code; stable while `id_br_valid`.
- `br_stall`  out  1  combinational; branch present but not accepted this cycle.
- `br_done`  out  1  registered one-cycle pulse; branch resolved.
- `br_taken`  out  1  registered; valid only with `br_done`.
- `flags`  out  3  architectural `{Z,V,N}` register.

## Operation
- Write mask by `ex_op`: ADD, SUB write Z, V, N. XOR, SLL, SRA, ROR write Z only. RED, PADDSB write nothing.
- Commit: on an edge with `ex_alu_valid && !hold`, the masked bits of `flags` take `ex_flags`; unmasked bits keep their value.
- Hazard: `haz = ex_alu_valid && (mask != 0)`.
- Conditions, evaluated on `flags`:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z && !N
  - 011 LT: N
  - 100 GE: Z || !N
  - 101 LE: Z || N
  - 110 OV: V
  - 111 always taken.
- FSM states: IDLE, WAIT.
  - IDLE: accept when `id_br_valid && !haz && !hold`. At that edge, register `br_done=1` and `br_taken=cond(flags)`; stay in IDLE.
  - IDLE: if `id_br_valid && haz && !hold`, go to WAIT and do not accept.
  - WAIT: the hazarding flags committed at the entering edge. Accept unconditionally unless `hold`, even if a new writer is in EX, because that writer is younger than the branch. Return to IDLE.
  - `hold` in either state: state unchanged, no acceptance.
- `br_stall = id_br_valid && !(accept)`.

## Timing
- Reset values: `flags`=000, `br_done`=0, `br_taken`=0, state IDLE. Reset is asynchronous and may arrive mid-WAIT; the pending branch is dropped and ID re-presents it.
- Latency, no hazard: accept edge T, `br_done` high in cycle T+1 only.
- Latency with hazard: one stall cycle, then accept; `br_done` is high 2 cycles after first presentation.
- `br_done` deasserts the cycle after it pulses, regardless of `hold`.
- Back-to-back branches: one per cycle in IDLE with no hazard.
- A branch accepted at the same edge as a flag commit from a non-writing op (RED, PADDSB) uses the pre-edge `flags`; this is correct because those ops do not change flags.
- `flags` updates exactly one edge after the qualifying EX cycle; there is no combinational path from `ex_flags` to `flags`.

## Structure
- Shared package `cpu_pkg`:
  - ALU opcode constants.
  - Condition-code constants.
  - `{Z,V,N}` bit indices.
  - Flag write-mask function keyed by opcode. The ALU bench and decoder reuse it.
- Sub-module `branch_cond_eval`: purely combinational, (`cond`, `flags`) → `taken`.
- The top level contains the flag register, mask logic, FSM and output registers.

## Test plan
- Reset, then ADD with `ex_flags`=011 → `flags`=011. Then XOR with `ex_flags`=100 → `flags`=111 (V and N kept).
- RED then PADDSB, both with `ex_flags`=111, starting from `flags`=000 → `flags` stays 000. A branch with cond 001 presented alongside either op gets no stall; one cycle later `br_done`=1, `br_taken`=0.
- SUB in EX with `ex_flags`=100 and an EQ branch in ID at the same time → `br_stall`=1 for one cycle, FSM in WAIT. Next cycle it is accepted; `br_done`=1, `br_taken`=1 two cycles after presentation.
- Walk all 8 conditions against `flags` ∈ {000, 100, 001, 010}. Spot checks: GT with 000 → taken; LE with 001 → taken; OV with 010 → taken; NE with 100 → not taken.
- `hold`=1 for 3 cycles with a branch pending and an ADD in EX → `br_stall`=1 throughout, `flags` unchanged. After release, the flags commit, then the branch resolves.
- Assert `rst_n`=0 while in WAIT → `flags`=000, `br_done`=0 immediately. After release, the re-presented unconditional branch (cond 111) gives `br_taken`=1.
